// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO drain-side stream reader.
package fifo_stream_reader_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic ONE   = 1'b1;
  localparam logic ZERO  = 1'b0;

endpackage

// File: rtl/fifo_stream_reader.sv
// Drains a fixed-latency FIFO read port into a credit-managed landing buffer
// and re-presents the words as a valid/ready stream.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int WIDTH             = 32,
  parameter int LATENCY           = 2,
  parameter int BUF_DEPTH_IN_BITS = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       fifo_empty,
  output logic                       fifo_req_r,
  input  logic [WIDTH-1:0]           fifo_data_r,
  input  logic                       fifo_valid_r,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BUF_DEPTH_IN_BITS:0] level,
  output logic                       error
);

  localparam int DEPTH = 1 << BUF_DEPTH_IN_BITS;
  localparam int PW    = BUF_DEPTH_IN_BITS;
  localparam int LW    = BUF_DEPTH_IN_BITS + 1;
  // At most one request per cycle, so no more than LATENCY reads are ever outstanding.
  localparam int IW    = $clog2(LATENCY + 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [LW-1:0]    count_q, count_d;
  logic [IW-1:0]    inflight_q, inflight_d;
  logic             error_q, error_d;
  logic             push;
  logic             pop;
  logic             stray;

  // Stream handshake: a word transfers on every rising edge where out_valid and
  // out_ready are both high; out_valid/out_data stay put until that happens.
  always_comb begin
    level      = count_q + LW'(inflight_q);
    fifo_req_r = !fifo_empty && (level < DEPTH_L);
    out_valid  = (count_q != '0) ? ONE : ZERO;
    out_data   = buf_q[rp_q];
    error      = error_q;
    pop        = out_valid && out_ready;
    stray      = fifo_valid_r && (inflight_q == '0);
    push       = fifo_valid_r && !stray;

    inflight_d = inflight_q;
    if (fifo_req_r && !push) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!fifo_req_r && push) begin
      inflight_d = inflight_q - IW'(1);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + LW'(1);
    end else if (!push && pop) begin
      count_d = count_q - LW'(1);
    end

    wp_d    = push ? wp_q + PW'(1) : wp_q;
    rp_d    = pop  ? rp_q + PW'(1) : rp_q;
    error_d = stray ? TRUE : error_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      error_q    <= FALSE;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      error_q    <= error_d;
    end
  end

  // Payload storage needs no reset: out_data is only meaningful while out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wp_q] <= fifo_data_r;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: emulated two-cycle FIFO, traffic counters and an in-order scoreboard.
module tb_fifo_stream_reader;

  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_valid_r = 1'b0;
  logic [W-1:0] fifo_data_r = '0;
  logic         out_ready = 1'b0;
  logic         fifo_req_r;
  logic         out_valid;
  logic         error;
  logic [W-1:0] out_data;
  logic [2:0]   level;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(.WIDTH(W), .LATENCY(2), .BUF_DEPTH_IN_BITS(2)) dut (
    .clk(clk), .reset_n(reset_n), .fifo_empty(fifo_empty), .fifo_req_r(fifo_req_r),
    .fifo_data_r(fifo_data_r), .fifo_valid_r(fifo_valid_r), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .level(level), .error(error)
  );

  // FIFO emulator: stored words and the two-stage read-return pipeline.
  logic [W-1:0] mem_q[$];
  logic         s1_v = 1'b0, s2_v = 1'b0;
  logic [W-1:0] s1_d = '0, s2_d = '0;
  logic         inject_stray = 1'b0;
  int           ready_pct = 100;

  // Scoreboard and traffic counters.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int n_req = 0, n_ret = 0, n_pop = 0;

  // Per-cycle expectations and samples.
  int   mdl_level;
  logic mdl_valid, mdl_req;
  logic smp_req, smp_valid, smp_err, smp_pop;
  logic [2:0] smp_level;

  task automatic clear_emulator();
    mem_q.delete();
    s1_v = 1'b0;
    s2_v = 1'b0;
    fifo_empty = 1'b1;
    fifo_valid_r = 1'b0;
  endtask

  task automatic clear_model();
    n_req = 0; n_ret = 0; n_pop = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_emulator();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_model();
  endtask

  // One clock cycle: drive inputs at negedge, sample just after, update emulator/model.
  task automatic step();
    logic         n1_v;
    logic [W-1:0] n1_d;
    @(negedge clk);
    fifo_empty   = (mem_q.size() == 0);
    fifo_valid_r = s2_v || inject_stray;
    fifo_data_r  = s2_v ? s2_d : W'($urandom());
    out_ready    = ($urandom_range(99) < ready_pct);
    inject_stray = 1'b0;
    mdl_level = n_req - n_pop;
    mdl_valid = (n_ret - n_pop) != 0;
    mdl_req   = !fifo_empty && (mdl_level < DEPTH);
    #1;
    smp_req   = fifo_req_r;
    smp_valid = out_valid;
    smp_level = level;
    smp_err   = error;
    smp_pop   = out_valid && out_ready;
    n1_v = 1'b0;
    n1_d = '0;
    if (fifo_req_r) begin
      n_req++;
      n1_v = 1'b1;
      n1_d = (mem_q.size() != 0) ? mem_q.pop_front() : 32'hdead_beef;
    end
    if (smp_pop) begin
      got_q.push_back(out_data);
      n_pop++;
    end
    if (s2_v) n_ret++;
    s2_v = s1_v; s2_d = s1_d;
    s1_v = n1_v; s1_d = n1_d;
  endtask

  task automatic test_reset();
    do_reset();
    ready_pct = 100;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++; if (smp_req !== 1'b0) $display("FAIL reset_req cyc=%0d got=%b exp=0", i, smp_req); else n_pass++;
      n_checks++; if (smp_valid !== 1'b0) $display("FAIL reset_valid cyc=%0d got=%b exp=0", i, smp_valid); else n_pass++;
      n_checks++; if (smp_level !== 3'd0) $display("FAIL reset_level cyc=%0d got=%0d exp=0", i, smp_level); else n_pass++;
      n_checks++; if (smp_err !== 1'b0) $display("FAIL reset_error cyc=%0d got=%b exp=0", i, smp_err); else n_pass++;
    end
  endtask

  task automatic test_stream();
    int first_req, first_val, last_pop, gaps;
    logic [W-1:0] g;
    first_req = -1; first_val = -1; last_pop = -1; gaps = 0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      mem_q.push_back(W'(32'h10 + i));
      exp_q.push_back(W'(32'h10 + i));
    end
    ready_pct = 100;
    for (int i = 0; i < 20; i++) begin
      step();
      n_checks++; if (smp_req !== mdl_req) $display("FAIL stream_req cyc=%0d got=%b exp=%b", i, smp_req, mdl_req); else n_pass++;
      n_checks++; if (int'(smp_level) !== mdl_level) $display("FAIL stream_level cyc=%0d got=%0d exp=%0d", i, smp_level, mdl_level); else n_pass++;
      n_checks++; if (smp_valid !== mdl_valid) $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, smp_valid, mdl_valid); else n_pass++;
      if (smp_req && first_req < 0) first_req = i;
      if (smp_valid && first_val < 0) first_val = i;
      if (smp_pop) begin
        if (last_pop >= 0 && i != last_pop + 1) gaps++;
        last_pop = i;
      end
    end
    n_checks++; if (first_val - first_req != 3) $display("FAIL stream_latency got=%0d exp=3", first_val - first_req); else n_pass++;
    n_checks++; if (gaps != 0) $display("FAIL stream_gaps got=%0d exp=0", gaps); else n_pass++;
    n_checks++; if (got_q.size() != 8) $display("FAIL stream_count got=%0d exp=8", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 32'hffff_ffff;
      n_checks++; if (g !== exp_q[i]) $display("FAIL stream_data idx=%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int reqs;
    logic [W-1:0] g;
    reqs = 0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      mem_q.push_back(W'(32'h10 + i));
      exp_q.push_back(W'(32'h10 + i));
    end
    ready_pct = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (smp_req) reqs++;
      n_checks++; if (smp_req !== mdl_req) $display("FAIL bp_req cyc=%0d got=%b exp=%b", i, smp_req, mdl_req); else n_pass++;
      n_checks++; if (int'(smp_level) !== mdl_level) $display("FAIL bp_level cyc=%0d got=%0d exp=%0d", i, smp_level, mdl_level); else n_pass++;
    end
    n_checks++; if (reqs != 4) $display("FAIL bp_requests got=%0d exp=4", reqs); else n_pass++;
    n_checks++; if (smp_level !== 3'd4) $display("FAIL bp_full_level got=%0d exp=4", smp_level); else n_pass++;
    n_checks++; if (smp_req !== 1'b0) $display("FAIL bp_full_req got=%b exp=0", smp_req); else n_pass++;
    n_checks++; if (got_q.size() != 0) $display("FAIL bp_no_pop got=%0d exp=0", got_q.size()); else n_pass++;
    ready_pct = 100;
    for (int i = 0; i < 25; i++) begin
      step();
      n_checks++; if (smp_valid !== mdl_valid) $display("FAIL bp_drain_valid cyc=%0d got=%b exp=%b", i, smp_valid, mdl_valid); else n_pass++;
    end
    n_checks++; if (got_q.size() != 8) $display("FAIL bp_count got=%0d exp=8", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 32'hffff_ffff;
      n_checks++; if (g !== exp_q[i]) $display("FAIL bp_data idx=%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    int pushed, cyc, bad_order;
    logic [W-1:0] w;
    pushed = 0; cyc = 0; bad_order = 0;
    got_q.delete(); exp_q.delete();
    ready_pct = 50;
    while (got_q.size() < 1000 && cyc < 20000) begin
      if (pushed < 1000 && $urandom_range(3) != 0) begin
        w = W'($urandom());
        mem_q.push_back(w);
        exp_q.push_back(w);
        pushed++;
      end
      step();
      cyc++;
      n_checks++; if (smp_level > 3'd4) $display("FAIL rand_level_bound cyc=%0d got=%0d exp<=4", cyc, smp_level); else n_pass++;
      n_checks++; if (int'(smp_level) !== mdl_level) $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", cyc, smp_level, mdl_level); else n_pass++;
      n_checks++; if (smp_req !== mdl_req) $display("FAIL rand_req cyc=%0d got=%b exp=%b", cyc, smp_req, mdl_req); else n_pass++;
      n_checks++; if (smp_valid !== mdl_valid) $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, smp_valid, mdl_valid); else n_pass++;
      n_checks++; if (smp_err !== 1'b0) $display("FAIL rand_error cyc=%0d got=%b exp=0", cyc, smp_err); else n_pass++;
    end
    n_checks++; if (got_q.size() != 1000) $display("FAIL rand_count got=%0d exp=1000 (cycle budget)", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        if (bad_order < 5) $display("FAIL rand_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
        bad_order++;
      end
    end
    n_checks++; if (bad_order != 0) $display("FAIL rand_order got=%0d bad words exp=0", bad_order); else n_pass++;
  endtask

  task automatic test_stray();
    logic [W-1:0] g;
    got_q.delete(); exp_q.delete();
    ready_pct = 100;
    repeat (4) step();
    inject_stray = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (smp_valid !== 1'b0) $display("FAIL stray_valid cyc=%0d got=%b exp=0", i, smp_valid); else n_pass++;
      n_checks++; if (smp_err !== 1'b1) $display("FAIL stray_error cyc=%0d got=%b exp=1", i, smp_err); else n_pass++;
      n_checks++; if (smp_level !== 3'd0) $display("FAIL stray_level cyc=%0d got=%0d exp=0", i, smp_level); else n_pass++;
    end
    mem_q.push_back(32'h0000_00a1); exp_q.push_back(32'h0000_00a1);
    mem_q.push_back(32'h0000_00a2); exp_q.push_back(32'h0000_00a2);
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++; if (smp_err !== 1'b1) $display("FAIL stray_sticky cyc=%0d got=%b exp=1", i, smp_err); else n_pass++;
    end
    n_checks++; if (got_q.size() != 2) $display("FAIL stray_count got=%0d exp=2", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 32'hffff_ffff;
      n_checks++; if (g !== exp_q[i]) $display("FAIL stray_data idx=%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
    do_reset();
    step();
    n_checks++; if (smp_err !== 1'b0) $display("FAIL stray_cleared got=%b exp=0", smp_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] g;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) mem_q.push_back(W'(32'h30 + i));
    ready_pct = 100;
    repeat (5) step();
    @(negedge clk);
    #3;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got=%b exp=1", out_valid); else n_pass++;
    reset_n = 1'b0;
    clear_emulator();
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (fifo_req_r !== 1'b0) $display("FAIL mid_rst_req got=%b exp=0", fifo_req_r); else n_pass++;
    n_checks++; if (level !== 3'd0) $display("FAIL mid_rst_level got=%0d exp=0", level); else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      mem_q.push_back(W'(32'h20 + i));
      exp_q.push_back(W'(32'h20 + i));
    end
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++; if (int'(smp_level) !== mdl_level) $display("FAIL mid_level cyc=%0d got=%0d exp=%0d", i, smp_level, mdl_level); else n_pass++;
      n_checks++; if (smp_valid !== mdl_valid) $display("FAIL mid_valid cyc=%0d got=%b exp=%b", i, smp_valid, mdl_valid); else n_pass++;
      n_checks++; if (smp_err !== 1'b0) $display("FAIL mid_error cyc=%0d got=%b exp=0", i, smp_err); else n_pass++;
    end
    n_checks++; if (got_q.size() != 4) $display("FAIL mid_count got=%0d exp=4", got_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 32'hffff_ffff;
      n_checks++; if (g !== exp_q[i]) $display("FAIL mid_data idx=%0d got=%h exp=%h", i, g, exp_q[i]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_stray();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
